// File: rtl/uart_tx_arbiter_if.sv
// Bundle of byte-producer and UART-side signals shared by the arbiter and whatever drives it.
// master = producers + UART model, slave = the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 8
);
    localparam int GRANT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]        src_start;
    logic [NUM_SRC*DATA_W-1:0] src_byte;
    logic [NUM_SRC-1:0]        src_lock;
    logic [NUM_SRC-1:0]        src_full;
    logic [NUM_SRC-1:0]        src_overflow;
    logic                      TxD_busy;
    logic                      TxD_Start;
    logic [DATA_W-1:0]         Byte_out;
    logic [GRANT_W-1:0]        grant_id;
    logic                      tx_active;

    modport master (
        output src_start, src_byte, src_lock, TxD_busy,
        input  src_full, src_overflow, TxD_Start, Byte_out, grant_id, tx_active
    );

    modport slave (
        input  src_start, src_byte, src_lock, TxD_busy,
        output src_full, src_overflow, TxD_Start, Byte_out, grant_id, tx_active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_SRC FIFO-buffered byte sources onto a single UART transmitter,
// fixed-priority or round-robin, with per-source lock for atomic multi-byte frames.
module uart_tx_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int GRANT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              state_reg, state_next;
    logic [NUM_SRC-1:0]  not_empty, pop_vec, cand, full_vec, ovf_vec;
    logic [DATA_W-1:0]   head [NUM_SRC];
    logic [GRANT_W-1:0]  grant_reg, rr_reg, pick_id, rr_next;
    logic [GRANT_W:0]    idx;
    logic [DATA_W-1:0]   byte_reg;
    logic                lock_held_reg, lock_eff, pick_valid, load_en, done_en;

    assign pop_vec = (state_reg == START) ? (NUM_SRC'(1) << grant_reg) : '0;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
            logic [DATA_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
            logic [PTR_W:0]    count_reg;
            logic              ovf_reg, full, push, pop;

            assign full = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
            assign pop  = pop_vec[gi];
            // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
            assign push = bus.src_start[gi] && (!full || pop);

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= bus.src_byte[gi*DATA_W +: DATA_W];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    ovf_reg    <= 1'b0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    if (push && !pop)      count_reg <= count_reg + (PTR_W+1)'(1);
                    else if (pop && !push) count_reg <= count_reg - (PTR_W+1)'(1);
                    if (bus.src_start[gi] && !push) ovf_reg <= 1'b1;
                end
            end

            assign head[gi]      = mem[rd_ptr_reg];
            assign not_empty[gi] = (count_reg != '0);
            assign full_vec[gi]  = full;
            assign ovf_vec[gi]   = ovf_reg;
        end
    endgenerate

    // A held lock only counts while the owner keeps src_lock asserted.
    assign lock_eff = lock_held_reg && bus.src_lock[grant_reg];
    assign cand     = not_empty & (lock_eff ? (NUM_SRC'(1) << grant_reg) : {NUM_SRC{1'b1}});
    assign rr_next  = (grant_reg == GRANT_W'(NUM_SRC - 1)) ? '0 : grant_reg + GRANT_W'(1);

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (ARB_MODE == 1) ? ({1'b0, rr_reg} + (GRANT_W+1)'(k)) : (GRANT_W+1)'(k);
            if (idx >= (GRANT_W+1)'(NUM_SRC)) idx = idx - (GRANT_W+1)'(NUM_SRC);
            if (!pick_valid && cand[idx[GRANT_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = idx[GRANT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        done_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    load_en    = 1'b1;
                    state_next = START;
                end
            end
            START:     state_next = bus.TxD_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_BUSY: if (bus.TxD_busy) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (!bus.TxD_busy) begin
                    done_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_reg     <= '0;
            byte_reg      <= '0;
            rr_reg        <= '0;
            lock_held_reg <= 1'b0;
        end else begin
            if (load_en) begin
                grant_reg <= pick_id;
                byte_reg  <= head[pick_id];
            end
            if (done_en) begin
                rr_reg        <= rr_next;
                lock_held_reg <= bus.src_lock[grant_reg];
            end else if (state_reg == IDLE && lock_held_reg && !bus.src_lock[grant_reg]) begin
                lock_held_reg <= 1'b0;
            end
        end
    end

    assign bus.src_full     = full_vec;
    assign bus.src_overflow = ovf_vec;
    assign bus.TxD_Start    = (state_reg == START);
    assign bus.Byte_out     = byte_reg;
    assign bus.grant_id     = grant_reg;
    assign bus.tx_active    = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: a fixed-priority 2-source and a round-robin 3-source arbiter,
// each with a UART busy model and an expected-byte scoreboard.
module tb_uart_tx_arbiter;
    localparam int BUSY_LEN = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_SRC(2), .DATA_W(8)) fp_if ();
    uart_tx_arbiter_if #(.NUM_SRC(3), .DATA_W(8)) rr_if ();

    uart_tx_arbiter #(.NUM_SRC(2), .DATA_W(8), .FIFO_DEPTH(4), .ARB_MODE(0))
        u_fp (.clk(clk), .rst(rst), .bus(fp_if));
    uart_tx_arbiter #(.NUM_SRC(3), .DATA_W(8), .FIFO_DEPTH(4), .ARB_MODE(1))
        u_rr (.clk(clk), .rst(rst), .bus(rr_if));

    typedef struct {int gid; logic [7:0] data;} exp_t;
    typedef struct {int src; logic [7:0] data; int lat;} vec_t;

    exp_t q_fp[$];
    exp_t q_rr[$];
    exp_t e_fp, e_rr;
    vec_t vecs[4];
    int   tests = 0;
    int   failed = 0;
    int   starts_fp = 0;
    int   starts_rr = 0;
    int   busy_cnt_fp = 0;
    int   busy_cnt_rr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART models and scoreboard monitors, all on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            fp_if.TxD_busy = 1'b0;
            rr_if.TxD_busy = 1'b0;
            busy_cnt_fp = 0;
            busy_cnt_rr = 0;
        end else begin
            if (fp_if.TxD_Start) begin
                starts_fp++;
                $display("[TB] fp tx grant=%0d byte=0x%02h", fp_if.grant_id, fp_if.Byte_out);
                if (q_fp.size() == 0) check("fp_unexpected_start", 1, 0);
                else begin
                    e_fp = q_fp.pop_front();
                    check("fp_grant", 32'(fp_if.grant_id), 32'(e_fp.gid));
                    check("fp_byte", 32'(fp_if.Byte_out), 32'(e_fp.data));
                end
                fp_if.TxD_busy = 1'b1;
                busy_cnt_fp = BUSY_LEN;
            end else if (busy_cnt_fp > 0) begin
                busy_cnt_fp--;
                if (busy_cnt_fp == 0) fp_if.TxD_busy = 1'b0;
            end
            if (rr_if.TxD_Start) begin
                starts_rr++;
                $display("[TB] rr tx grant=%0d byte=0x%02h", rr_if.grant_id, rr_if.Byte_out);
                if (q_rr.size() == 0) check("rr_unexpected_start", 1, 0);
                else begin
                    e_rr = q_rr.pop_front();
                    check("rr_grant", 32'(rr_if.grant_id), 32'(e_rr.gid));
                    check("rr_byte", 32'(rr_if.Byte_out), 32'(e_rr.data));
                end
                rr_if.TxD_busy = 1'b1;
                busy_cnt_rr = BUSY_LEN;
            end else if (busy_cnt_rr > 0) begin
                busy_cnt_rr--;
                if (busy_cnt_rr == 0) rr_if.TxD_busy = 1'b0;
            end
        end
    end

    task automatic drive_fp(input logic [1:0] st, input logic [15:0] b);
        fp_if.src_start = st;
        fp_if.src_byte  = b;
        @(negedge clk);
        fp_if.src_start = '0;
    endtask

    task automatic drive_rr(input logic [2:0] st, input logic [23:0] b);
        rr_if.src_start = st;
        rr_if.src_byte  = b;
        @(negedge clk);
        rr_if.src_start = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((q_fp.size() != 0 || q_rr.size() != 0 || fp_if.tx_active || rr_if.tx_active ||
                fp_if.TxD_busy || rr_if.TxD_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, 32'(n < 400), 1);
    endtask

    task automatic wait_start_fp(output int lat);
        lat = 1;
        while (!fp_if.TxD_Start && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n;
        int s;
        logic [15:0] b;

        vecs[0] = '{1, 8'hA5, 2};
        vecs[1] = '{0, 8'h3C, 2};
        vecs[2] = '{1, 8'hFF, 2};
        vecs[3] = '{0, 8'h00, 2};

        fp_if.src_start = '0; fp_if.src_byte = '0; fp_if.src_lock = '0; fp_if.TxD_busy = 1'b0;
        rr_if.src_start = '0; rr_if.src_byte = '0; rr_if.src_lock = '0; rr_if.TxD_busy = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_start", 32'(fp_if.TxD_Start), 0);
        check("rst_active", 32'(fp_if.tx_active), 0);
        check("rst_byte", 32'(fp_if.Byte_out), 0);
        check("rst_grant", 32'(fp_if.grant_id), 0);
        check("rst_full", 32'(fp_if.src_full), 0);
        check("rst_ovf", 32'(fp_if.src_overflow), 0);
        check("rst_rr_active", 32'(rr_if.tx_active), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table of single-byte launches: latency, byte/grant and idle hold.
        for (int i = 0; i < 4; i++) begin
            q_fp.push_back('{vecs[i].src, vecs[i].data});
            b = 16'(vecs[i].data) << (8 * vecs[i].src);
            drive_fp(2'(1 << vecs[i].src), b);
            wait_start_fp(lat);
            check("vec_latency", 32'(lat), 32'(vecs[i].lat));
            wait_idle("vec");
            check("vec_hold_byte", 32'(fp_if.Byte_out), 32'(vecs[i].data));
            check("vec_hold_grant", 32'(fp_if.grant_id), 32'(vecs[i].src));
        end

        // Fixed priority: simultaneous pushes, src0 goes first.
        q_fp.push_back('{0, 8'h11});
        q_fp.push_back('{1, 8'h22});
        drive_fp(2'b11, 16'h2211);
        wait_idle("prio");

        // Overflow: five pushes into src1 while src0's byte is on the wire.
        q_fp.push_back('{0, 8'h50});
        drive_fp(2'b01, 16'h0050);
        wait_start_fp(lat);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) q_fp.push_back('{1, 8'(8'h61 + i)});
            drive_fp(2'b10, 16'(8'h61 + i) << 8);
        end
        check("ovf_full1", 32'(fp_if.src_full[1]), 1);
        check("ovf_flag1", 32'(fp_if.src_overflow[1]), 1);
        check("ovf_full0", 32'(fp_if.src_full[0]), 0);
        check("ovf_flag0", 32'(fp_if.src_overflow[0]), 0);
        wait_idle("ovf");
        check("ovf_drained", 32'(fp_if.src_full[1]), 0);
        check("ovf_sticky", 32'(fp_if.src_overflow[1]), 1);

        // Lock: src1 frame of 3 bytes holds off pending src0 until lock drops.
        fp_if.src_lock = 2'b10;
        q_fp.push_back('{1, 8'hB1});
        drive_fp(2'b10, 16'hB100);
        wait_start_fp(lat);
        check("lock_latency", 32'(lat), 2);
        q_fp.push_back('{1, 8'hB2});
        q_fp.push_back('{1, 8'hB3});
        q_fp.push_back('{0, 8'h0A});
        drive_fp(2'b11, 16'hB20A);
        drive_fp(2'b10, 16'hB300);
        n = 0;
        while ((q_fp.size() > 1 || fp_if.tx_active) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("lock_frame_timeout", 32'(n < 200), 1);
        repeat (20) @(negedge clk);
        check("lock_starve_q", 32'(q_fp.size()), 1);
        check("lock_starve_idle", 32'(fp_if.tx_active), 0);
        fp_if.src_lock = 2'b00;
        wait_idle("lock_release");

        // Round-robin: two bytes in every FIFO -> 0,1,2,0,1,2.
        for (int r = 0; r < 2; r++)
            for (int sidx = 0; sidx < 3; sidx++)
                q_rr.push_back('{sidx, 8'(16 * sidx + r)});
        drive_rr(3'b111, 24'h201000);
        drive_rr(3'b111, 24'h211101);
        wait_idle("rr_order");
        // Pointer wrap: after serving src1, src2 is empty so src0 precedes src1.
        q_rr.push_back('{1, 8'h30});
        drive_rr(3'b010, 24'h003000);
        wait_idle("rr_single");
        q_rr.push_back('{0, 8'h40});
        q_rr.push_back('{1, 8'h41});
        drive_rr(3'b011, 24'h004140);
        wait_idle("rr_wrap");
        check("rr_hold_grant", 32'(rr_if.grant_id), 1);

        // Reset during WAIT_DONE with another byte pending.
        q_fp.push_back('{1, 8'h77});
        drive_fp(2'b10, 16'h7700);
        wait_start_fp(lat);
        @(negedge clk);
        drive_fp(2'b01, 16'h0088);
        check("pre_rst_active", 32'(fp_if.tx_active), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_active", 32'(fp_if.tx_active), 0);
        check("mid_rst_start", 32'(fp_if.TxD_Start), 0);
        check("mid_rst_byte", 32'(fp_if.Byte_out), 0);
        check("mid_rst_grant", 32'(fp_if.grant_id), 0);
        check("mid_rst_ovf", 32'(fp_if.src_overflow), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        s = starts_fp;
        repeat (20) @(negedge clk);
        check("post_rst_no_start", 32'(starts_fp), 32'(s));
        check("post_rst_idle", 32'(fp_if.tx_active), 0);

        check("fp_queue_empty", 32'(q_fp.size()), 0);
        check("rr_queue_empty", 32'(q_rr.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
